lz_normalize_pipe: RTL

//  Two-stage valid/ready pipeline that normalises an operand: stage 1 counts leading zeros
//  (or ones) with leading_zero_one_cnt; stage 2 shifts the operand left by that count.

---
 rtl/lz_normalize_pipe.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lz_normalize_pipe.sv
// lz_normalize_pipe: two-stage valid/ready normaliser.
//   Stage 1 registers the operand, its tag and its leading zero (or one) count.
//   Stage 2 registers the operand shifted left by that count, the count, the tag
//   and an all-zero/all-one flag.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
//   a producer holds its payload stable while valid=1 and ready=0, and flush kills
//   every in-flight entry with priority over any handshake in the same cycle.
// Optional build macro LZN_SKID_EN: a one-entry skid buffer in front of stage 1
//   makes in_ready a registered signal with no combinational path from out_ready.
module lz_normalize_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH  = 6,
  parameter int COUNT_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(DATA_WIDTH):0]   out_cnt,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_zero
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // Stage registers
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [CW-1:0]         s1_cnt;
  logic                  s2_valid;
  logic [DATA_WIDTH-1:0] s2_data;
  logic [CW-1:0]         s2_cnt;
  logic [TAG_WIDTH-1:0]  s2_tag;
  logic                  s2_zero;

  // Advance controls and the stage-1 source (input port or skid entry)
  logic                  s2_load;
  logic                  s1_load;
  logic                  src_valid;
  logic [DATA_WIDTH-1:0] src_data;
  logic [TAG_WIDTH-1:0]  src_tag;
  logic [DATA_WIDTH-1:0] lz_vec;
  logic [CW-1:0]         src_cnt;
  logic [DATA_WIDTH-1:0] shift_lvl;

  // A stage may load when it is empty or its content leaves this cycle
  always_comb begin
    s2_load = !s2_valid || out_ready;
    s1_load = !s1_valid || s2_load;
  end

`ifdef LZN_SKID_EN
  logic                  sk_valid;
  logic [DATA_WIDTH-1:0] sk_data;
  logic [TAG_WIDTH-1:0]  sk_tag;

  // The skid entry is older than anything on the port, so it feeds stage 1 first
  always_comb begin
    src_valid = sk_valid || in_valid;
    src_data  = sk_valid ? sk_data : in_data;
    src_tag   = sk_valid ? sk_tag  : in_tag;
    in_ready  = !sk_valid && !flush;
  end

  // Park an accepted operand that stage 1 cannot take; drain it when stage 1 loads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_valid <= 1'b0;
      sk_data  <= '0;
      sk_tag   <= '0;
    end else if (flush) begin
      sk_valid <= 1'b0;
    end else if (sk_valid) begin
      if (s1_load) sk_valid <= 1'b0;
    end else if (in_valid && !s1_load) begin
      sk_valid <= 1'b1;
      sk_data  <= in_data;
      sk_tag   <= in_tag;
    end
  end
`else
  // Without a skid, the port feeds stage 1 directly and ready follows stage 1
  always_comb begin
    src_valid = in_valid;
    src_data  = in_data;
    src_tag   = in_tag;
    in_ready  = s1_load && !flush;
  end
`endif

  // Leading zero/one count: the highest marked bit wins; none marked gives DATA_WIDTH
  always_comb begin
    lz_vec  = (COUNT_ZERO != 0) ? src_data : ~src_data;
    src_cnt = CW'(DATA_WIDTH);
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (lz_vec[i]) src_cnt = CW'(DATA_WIDTH - 1 - i);
    end
  end

  // Log2 barrel shifter, one level per count bit; the top level clears the word
  always_comb begin
    shift_lvl = s1_data;
    for (int i = 0; i < CW; i++) begin
      if (s1_cnt[i]) shift_lvl = shift_lvl << (1 << i);
    end
  end

  // Stage 1: capture operand, tag and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tag   <= '0;
      s1_cnt   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= src_valid;
      if (src_valid) begin
        s1_data <= src_data;
        s1_tag  <= src_tag;
        s1_cnt  <= src_cnt;
      end
    end
  end

  // Stage 2: capture the normalised operand and its flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_cnt   <= '0;
      s2_tag   <= '0;
      s2_zero  <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= shift_lvl;
        s2_cnt  <= s1_cnt;
        s2_tag  <= s1_tag;
        s2_zero <= (s1_cnt == CW'(DATA_WIDTH));
      end
    end
  end

  // Outputs come straight from stage 2; flush hides the result in its own cycle
  always_comb begin
    out_valid = s2_valid && !flush;
    out_data  = s2_data;
    out_cnt   = s2_cnt;
    out_tag   = s2_tag;
    out_zero  = s2_zero;
  end

endmodule
